// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target fronting a 16x8 register file with a host-side port.
//   CLK, nRESET         system clock, asynchronous active-low reset
//   SCK, MOSI, nSS      raw SPI inputs from the initiator (synchronized internally)
//   MISO, MISO_OE       serial data out (MSB first) and its output enable
//   hwe, haddr, hwdata  host-side register write port
//   hrdata              combinational read of reg[haddr]
//   wstb, waddr, wdata  one-CLK notification of each SPI register write
//   busy                transfer in progress (FSM not IDLE)
module spi_target #(
    parameter logic [7:0] ID   = 8'h5A,
    parameter int         SYNC = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic       hwe,
    input  logic [3:0] haddr,
    input  logic [7:0] hwdata,
    output logic [7:0] hrdata,
    output logic       wstb,
    output logic [3:0] waddr,
    output logic [7:0] wdata,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMD   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [SYNC-1:0] sck_s, mosi_s, nss_s, vld;
    logic            sck_d, nss_d, armed;
    logic [1:0]      state;
    logic [2:0]      bitcnt;
    logic [3:0]      ptr;
    logic [7:0]      tx, rx, rx_next;
    logic [7:0]      regs [16];
    logic            sck, mosi, nss, sck_rise, sck_fall, nss_fall, nss_rise;
    logic            act, done, spi_we;

    assign sck      = sck_s[SYNC-1];
    assign mosi     = mosi_s[SYNC-1];
    assign nss      = nss_s[SYNC-1];
    assign sck_rise = sck & ~sck_d;
    assign sck_fall = ~sck & sck_d;
    // A falling nSS only counts once the synchronizer has shown a real high
    // level, so a select held low across reset release is not a new transfer.
    assign nss_fall = armed & nss_d & ~nss;
    assign nss_rise = ~nss_d & nss;
    assign act      = (state != IDLE) & ~nss_rise;
    assign done     = act & sck_rise & (bitcnt == 3'd7);
    assign rx_next  = {rx[6:0], mosi};
    assign spi_we   = done & (state == WDATA);
    assign MISO_OE  = ~nss;
    assign MISO     = nss ? 1'b1 : tx[7];
    assign busy     = state != IDLE;
    assign hrdata   = regs[haddr];

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sck_s  <= '0;
            mosi_s <= '0;
            nss_s  <= '1;
            vld    <= '0;
            sck_d  <= 1'b0;
            nss_d  <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sck_s  <= SYNC'({sck_s, SCK});
            mosi_s <= SYNC'({mosi_s, MOSI});
            nss_s  <= SYNC'({nss_s, nSS});
            vld    <= SYNC'({vld, 1'b1});
            sck_d  <= sck;
            nss_d  <= nss;
            armed  <= armed | (vld[SYNC-1] & nss);
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state  <= IDLE;
            bitcnt <= 3'd0;
            ptr    <= 4'd0;
            tx     <= 8'hFF;
            rx     <= 8'h00;
            wstb   <= 1'b0;
            waddr  <= 4'd0;
            wdata  <= 8'h00;
        end else begin
            wstb <= spi_we;
            if (spi_we) begin
                waddr <= ptr;
                wdata <= rx_next;
            end
            if (state == IDLE) begin
                if (nss_fall) begin
                    state  <= CMD;
                    bitcnt <= 3'd0;
                    tx     <= ID;
                end
            end else if (nss_rise) begin
                state <= IDLE;
            end else begin
                if (sck_rise) begin
                    rx     <= rx_next;
                    bitcnt <= bitcnt + 3'd1;
                end
                // bitcnt==0 on a fall means a byte was just loaded; keep its MSB.
                if (sck_fall && bitcnt != 3'd0)
                    tx <= {tx[6:0], 1'b1};
                if (done) begin
                    if (state == CMD) begin
                        ptr   <= rx_next[3:0];
                        state <= rx_next[7] ? RDATA : WDATA;
                        if (rx_next[7])
                            tx <= regs[rx_next[3:0]];
                    end else begin
                        ptr <= ptr + 4'd1;
                        if (state == RDATA)
                            tx <= regs[ptr + 4'd1];
                    end
                end
            end
        end
    end

    // SPI write is issued last so it overrides a host write to the same register.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= 8'h00;
        end else begin
            if (hwe)
                regs[haddr] <= hwdata;
            if (spi_we)
                regs[ptr] <= rx_next;
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and randomized transfers against a register-array model of spi_target.
module tb_spi_target;
    localparam int         HP = 4;
    localparam logic [7:0] ID = 8'h5A;

    logic       CLK = 1'b0;
    logic       nRESET, SCK, MOSI, nSS, hwe;
    logic [3:0] haddr;
    logic [7:0] hwdata;
    logic       MISO, MISO_OE, wstb, busy;
    logic [3:0] waddr;
    logic [7:0] wdata, hrdata;

    spi_target #(.ID(ID), .SYNC(2)) dut (
        .CLK(CLK), .nRESET(nRESET), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
        .MISO(MISO), .MISO_OE(MISO_OE), .hwe(hwe), .haddr(haddr), .hwdata(hwdata),
        .hrdata(hrdata), .wstb(wstb), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  m [16];
    logic [7:0]  buf_d [16];
    logic [11:0] wq [$];
    logic        col_arm = 1'b0;

    always @(negedge CLK)
        if (wstb === 1'b1)
            wq.push_back({waddr, wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] a, input logic [7:0] exp);
        haddr = a;
        #1;
        chk("hrdata", {28'd0, a, hrdata}, {28'd0, a, exp});
    endtask

    task automatic hw(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        haddr = a; hwdata = d; hwe = 1'b1;
        @(negedge CLK);
        hwe = 1'b0;
        m[a] = d;
    endtask

    task automatic select();
        wq.delete();
        @(negedge CLK);
        nSS = 1'b0;
        repeat (6) @(negedge CLK);
        chk("busy_active", busy, 1'b1);
        chk("oe_active", MISO_OE, 1'b1);
    endtask

    task automatic deselect();
        repeat (HP) @(negedge CLK);
        nSS = 1'b1;
        repeat (HP + 4) @(negedge CLK);
        chk("busy_idle", busy, 1'b0);
    endtask

    // One mode-0 bit: MISO is sampled just before SCK rises. With col_arm the
    // host write strobe lands on the CLK where the SPI byte completes.
    task automatic spi_bit(input logic b, output logic r);
        MOSI = b;
        repeat (HP) @(negedge CLK);
        r = MISO;
        SCK = 1'b1;
        for (int i = 0; i < HP; i++) begin
            @(negedge CLK);
            hwe = col_arm && i == 1;
        end
        SCK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] o, output logic [7:0] r, input bit col);
        for (int i = 0; i < 8; i++) begin
            col_arm = col && i == 7;
            spi_bit(o[7-i], r[7-i]);
        end
        col_arm = 1'b0;
    endtask

    task automatic spi_write(input logic [3:0] a, input int n);
        logic [7:0] r;
        logic [3:0] p;
        select();
        spi_byte({4'h0, a}, r, 1'b0);
        chk("wr_status", r, ID);
        for (int i = 0; i < n; i++) begin
            spi_byte(buf_d[i], r, 1'b0);
            p = a + 4'(i);
            m[p] = buf_d[i];
        end
        deselect();
        chk("wstb_count", wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            p = a + 4'(i);
            chk("wstb_addr_data", wq[i], {p, buf_d[i]});
        end
    endtask

    task automatic spi_read(input logic [3:0] a, input int n, input logic [2:0] u);
        logic [7:0] r;
        logic [3:0] p;
        select();
        spi_byte({1'b1, u, a}, r, 1'b0);
        chk("rd_status", r, ID);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), r, 1'b0);
            p = a + 4'(i);
            chk("rd_data", r, m[p]);
        end
        deselect();
        chk("rd_no_wstb", wq.size(), 0);
    endtask

    initial begin
        logic [7:0] r;
        logic       b;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        nRESET = 1'b0; SCK = 1'b0; MOSI = 1'b0; nSS = 1'b1;
        hwe = 1'b0; haddr = 4'd0; hwdata = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_miso", MISO, 1'b1);
        chk("rst_oe", MISO_OE, 1'b0);
        chk("rst_wstb", wstb, 1'b0);
        chk("rst_waddr", waddr, 4'd0);
        chk("rst_wdata", wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk_reg(4'd0, 8'h00);
        chk_reg(4'd15, 8'h00);
        nRESET = 1'b1;
        repeat (6) @(negedge CLK);

        buf_d[0] = 8'h11; buf_d[1] = 8'h22;
        spi_write(4'd3, 2);
        chk_reg(4'd3, 8'h11);
        chk_reg(4'd4, 8'h22);

        hw(4'd7, 8'hC3);
        spi_read(4'd7, 1, 3'd0);

        buf_d[0] = 8'hAA; buf_d[1] = 8'hBB;
        spi_write(4'd15, 2);
        chk_reg(4'd15, 8'hAA);
        chk_reg(4'd0, 8'hBB);
        spi_read(4'd15, 2, 3'd0);

        hw(4'd5, 8'h3C);
        select();
        spi_byte(8'h05, r, 1'b0);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        nSS = 1'b1;
        repeat (3) @(negedge CLK);
        chk("abort_busy", busy, 1'b0);
        repeat (4) @(negedge CLK);
        chk("abort_no_wstb", wq.size(), 0);
        chk_reg(4'd5, 8'h3C);
        buf_d[0] = 8'h77;
        spi_write(4'd5, 1);
        chk_reg(4'd5, 8'h77);

        haddr = 4'd2; hwdata = 8'h55;
        select();
        spi_byte(8'h02, r, 1'b0);
        spi_byte(8'h66, r, 1'b1);
        deselect();
        m[2] = 8'h66;
        chk("col_wstb_count", wq.size(), 1);
        chk_reg(4'd2, 8'h66);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
            spi_write(4'($urandom_range(0, 15)), n);
            if ($urandom_range(0, 1) == 1) hw(4'($urandom_range(0, 15)), 8'($urandom));
            spi_read(4'($urandom_range(0, 15)), $urandom_range(1, 4), 3'($urandom));
        end
        for (int i = 0; i < 16; i++) chk_reg(4'(i), m[i]);

        select();
        spi_byte(8'h83, r, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        chk("rst2_oe", MISO_OE, 1'b0);
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_miso", MISO, 1'b1);
        for (int i = 0; i < 16; i++) begin
            m[i] = 8'h00;
            chk_reg(4'(i), 8'h00);
        end
        @(negedge CLK);
        nRESET = 1'b1;
        wq.delete();
        for (int i = 0; i < 16; i++) spi_bit(1'($urandom), b);
        repeat (4) @(negedge CLK);
        chk("rst2_no_wstb", wq.size(), 0);
        chk("rst2_idle", busy, 1'b0);
        nSS = 1'b1;
        repeat (6) @(negedge CLK);
        buf_d[0] = 8'h9E;
        spi_write(4'd9, 1);
        spi_read(4'd8, 3, 3'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter ID, default 8'h5A: status byte shifted out during the command byte.
REQ-002 SHALL have parameter SYNC, default 2: synchronizer depth (flops) on SCK, MOSI, nSS.
REQ-003 SHALL have port CLK  input  1  system clock; all state on posedge CLK.
REQ-004 SHALL have port nRESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SCK  input  1  SPI clock from the bit-banged initiator, mode 0.
REQ-006 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 SHALL have port nSS  input  1  active-low target select.
REQ-008 SHALL have port MISO  output  1  serial data out, MSB first.
REQ-009 SHALL have port MISO_OE  output  1  high while the synchronized nSS is low; board drives MISO only then.
REQ-010 SHALL have port hwe  input  1  host-side register write strobe.
REQ-011 SHALL have port haddr  input  4  host-side register address.
REQ-012 SHALL have port hwdata  input  8  host-side write data.
REQ-013 SHALL have port hrdata  output  8  combinational read of reg[haddr].
REQ-014 SHALL have port wstb  output  1  one-CLK pulse per SPI register write.
REQ-015 SHALL have port waddr  output  4  address of the last SPI write; valid with wstb, held after.
REQ-016 SHALL have port wdata  output  8  data of the last SPI write; valid with wstb, held after.
REQ-017 SHALL have port busy  output  1  high while the FSM is not IDLE.

Function
REQ-018 SHALL pass SCK, MOSI and nSS through SYNC-flop synchronizers, then detect SCK rise and fall edges on the synchronized signals.
REQ-019 SHALL support initiator SCK high and low phases of at least SYNC+1 CLK periods each; faster input is outside the operating range.
REQ-020 SHALL implement a 16 x 8 register file reg[0..15].
REQ-021 SHALL implement FSM states IDLE, CMD, WDATA, RDATA.
REQ-022 SHALL move from IDLE to CMD on the synchronized nSS falling, clear bitcnt, and load the tx shifter with ID.
REQ-023 SHALL, on each SCK rise, shift MOSI into rx LSB and increment a 3-bit bitcnt; the 8th rise (bitcnt 7 -> 0) completes a byte.
REQ-024 SHALL, on each SCK fall, shift tx left only when bitcnt != 0, so a byte loaded at byte completion is not shifted by the following fall.
REQ-025 SHALL drive MISO = tx[7] while MISO_OE is high, and drive MISO = 1 otherwise.
REQ-026 SHALL decode the command byte as: bit7 = 1 read, 0 write; bits[6:4] ignored; bits[3:0] = start address ptr.
REQ-027 SHALL, on command-byte completion, go to RDATA for a read and load tx = reg[ptr] in the same CLK; for a write it SHALL go to WDATA.
REQ-028 SHALL, in WDATA on each byte completion, write reg[ptr] = rx, pulse wstb for 1 CLK with waddr = ptr and wdata = rx, then increment ptr.
REQ-029 SHALL, in RDATA on each byte completion, increment ptr and load tx = reg[ptr+1]; tx data bytes SHALL be don't-care in WDATA.
REQ-030 SHALL wrap ptr modulo 16 (15 -> 0) with no error.
REQ-031 SHALL give the SPI write priority when it and hwe target the same register in the same CLK; the host write is lost.
REQ-032 SHALL load the pre-write value into tx when a host write and an RDATA tx load hit the same register in the same CLK.
REQ-033 SHALL, on synchronized nSS rising in any state, go to IDLE the next CLK, discard the partial byte, and keep completed writes.
REQ-034 SHALL ignore SCK edges while in IDLE, i.e. while nSS is high.
REQ-035 SHALL, in steady state, present a written register on hrdata no later than the CLK after wstb.

Reset
REQ-036 SHALL, while nRESET is low, clear all reg[] to 8'h00, set state = IDLE, bitcnt = 0, ptr = 0, tx = 8'hFF, rx = 0, and set the synchronizer flops to SCK = 0, MOSI = 0, nSS = 1.
REQ-037 SHALL hold outputs MISO = 1, MISO_OE = 0, wstb = 0, waddr = 0, wdata = 0, busy = 0 while nRESET is low.
REQ-038 SHALL, after reset is released mid-transfer, stay in IDLE until a fresh nSS falling edge.

Verification
REQ-039 Write: nSS low, send 8'h03, 8'h11, 8'h22 -> wstb pulses twice, (waddr, wdata) = (3, 11) then (4, 22), reg3 = 11, reg4 = 22.
REQ-040 Read with status: host writes reg7 = C3, then nSS low, send 8'h87, 8'h00 -> MISO yields 5A during the command byte, then C3.
REQ-041 Wrap: write cmd 8'h0F with data AA, BB -> reg15 = AA, reg0 = BB; read cmd 8'h8F -> AA, BB.
REQ-042 Abort: nSS rises after 5 bits of a write data byte -> no wstb, reg unchanged, busy = 0 after SYNC+1 CLK; the next transfer behaves normally.
REQ-043 Collision: hwe to reg2 = 55 in the same CLK as SPI write reg2 = 66 -> reg2 = 66.
REQ-044 Reset: assert nRESET mid-RDATA -> all regs 00, MISO_OE = 0, busy = 0; SCK toggles with nSS held low produce no wstb.
